apb_s5_completer: RTL and testbench

APB_S5_COMPLETER -- requirements
Module: apb_s5_completer

---
 rtl/apb_s5_completer.sv | 149 ++++++++++++++
 tb/tb_apb_s5_completer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_s5_completer.sv
// APB completer with a NUM_REGS x 32-bit register file; register 0 is a read-only ID.
// Optional wait-state insertion is enabled by defining S5_COMPLETER_WAIT_EN.
module apb_s5_completer #(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] ID_VALUE    = 32'h0005_0001,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        S5_PSEL,
    input  logic        S5_PENABLE,
    input  logic        S5_PWRITE,
    input  logic [31:0] S5_PADDR,
    input  logic [31:0] S5_PDATA,
    input  logic [3:0]  S5_PSTRB,
    output logic [31:0] S5_PRDATA,
    output logic        S5_PREADY,
    output logic        S5_PSLVERR
);

    localparam int IW = $clog2(NUM_REGS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    // Handshake: a transfer starts with a SETUP cycle (PSEL=1, PENABLE=0) seen in IDLE,
    // then holds PSEL=1, PENABLE=1 until the single cycle where PREADY=1; dropping PSEL
    // before that aborts it. PSLVERR and PRDATA are meaningful only while PREADY=1.
    logic [1:0]  state_q;
    logic [1:0]  state;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        pready_q;
    logic        pslverr_q;
    logic [31:0] prdata_q;
    logic [31:0] regs [NUM_REGS];

    logic [31:0]   dec_addr;
    logic          dec_wr;
    logic [IW-1:0] dec_idx;
    logic          dec_err;
    logic [31:0]   rd_val;
    logic          completing;
    logic          commit;
    logic [IW-1:0] wr_idx;
    logic          wait_done;

    // SETUP is recognised combinationally so that PREADY can rise in the very next cycle.
    always_comb begin
        state = state_q;
        if (state_q == IDLE && S5_PSEL && !S5_PENABLE) state = SETUP;
    end

    always_comb begin
        dec_addr = (state == SETUP) ? S5_PADDR  : addr_q;
        dec_wr   = (state == SETUP) ? S5_PWRITE : wr_q;
        dec_idx  = dec_addr[IW+1:2];
        dec_err  = (dec_addr[1:0] != 2'b00) || (dec_addr >= 32'(NUM_REGS * 4))
                   || (dec_wr && dec_idx == '0);
        rd_val   = '0;
        if (!dec_err && !dec_wr) rd_val = (dec_idx == '0) ? ID_VALUE : regs[dec_idx];
    end

`ifdef S5_COMPLETER_WAIT_EN
    localparam logic [3:0] WAIT_LD     = 4'(WAIT_CYCLES);
    localparam bit         SETUP_READY = (WAIT_LD == 4'd0);
    logic [3:0] wait_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wait_q <= 4'd0;
        end else if (state == SETUP) begin
            wait_q <= WAIT_LD;
        end else if (state == ACCESS && S5_PSEL && !pready_q && wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
        end
    end

    assign wait_done = (wait_q == 4'd1);
`else
    // WAIT_CYCLES has no effect in this build: every transfer completes in its first access cycle.
    localparam bit SETUP_READY = 1'b1 | WAIT_CYCLES[0];
    assign wait_done = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state)
                SETUP: begin
                    state_q <= ACCESS;
                    wr_q    <= S5_PWRITE;
                    addr_q  <= S5_PADDR;
                    data_q  <= S5_PDATA;
                    strb_q  <= S5_PSTRB;
                    if (SETUP_READY) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= dec_err;
                        prdata_q  <= rd_val;
                    end
                end
                ACCESS: begin
                    if (!S5_PSEL || pready_q) begin
                        state_q <= IDLE;
                    end else if (wait_done) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= dec_err;
                        prdata_q  <= rd_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // A write lands on the edge that closes its completion cycle, never on an abort.
    assign completing = (state_q == ACCESS) && pready_q && S5_PSEL;
    assign commit     = completing && wr_q && !pslverr_q;
    assign wr_idx     = addr_q[IW+1:2];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) regs[wr_idx][8*b +: 8] <= data_q[8*b +: 8];
            end
        end
    end

    assign S5_PREADY  = pready_q & S5_PSEL;
    assign S5_PSLVERR = pslverr_q & S5_PSEL;
    assign S5_PRDATA  = S5_PSEL ? prdata_q : 32'h0;

endmodule

// File: tb/tb_apb_s5_completer.sv
// Randomised bench for apb_s5_completer against a register-array reference model.
// Honours S5_COMPLETER_WAIT_EN to pick the expected transfer length.
module tb_apb_s5_completer;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] ID       = 32'h0005_0001;
`ifdef S5_COMPLETER_WAIT_EN
    localparam int WAITS = 3;
`else
    localparam int WAITS = 0;
`endif
    localparam int ACC_CYC = WAITS + 1;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mregs [NUM_REGS];
    logic [31:0] last_rd;

    apb_s5_completer #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID), .WAIT_CYCLES(3)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .S5_PSEL(psel), .S5_PENABLE(penable), .S5_PWRITE(pwrite),
        .S5_PADDR(paddr), .S5_PDATA(pwdata), .S5_PSTRB(pstrb),
        .S5_PRDATA(prdata), .S5_PREADY(pready), .S5_PSLVERR(pslverr)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic model_err(input logic wr, input logic [31:0] a);
        return (a % 4 != 0) || (a >= NUM_REGS * 4) || (wr && a < 4);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
    endtask

    // driver: one full transfer, leaving the bus as-is so the next call can go back-to-back
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        logic        e_err;
        logic [31:0] e_rd;
        int          n;
        bit          done;
        e_err = model_err(wr, addr);
        e_rd  = (wr || e_err) ? 32'h0 : ((addr == 0) ? ID : mregs[addr / 4]);
        exp_q.push_back(e_rd);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clk);
        check("setup_ready_low", pready, 0);
        @(posedge clk); #1;
        penable = 1'b1;
        // late changes of the request must not matter
        paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom_range(0, 15));
        pwrite = 1'($urandom_range(0, 1));
        n = 0; done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (pready === 1'b1) done = 1;
            else @(posedge clk);
        end
        check("ready_seen", 32'(done), 1);
        check("access_cycles", n, ACC_CYC);
        last_rd = prdata;
        check("prdata", prdata, exp_q.pop_front());
        check("pslverr", pslverr, e_err);
        if (wr && !e_err && done) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[addr / 4][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // idle cycles; stray drives PSEL=1,PENABLE=1 without a setup phase
    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel = stray; penable = stray;
            @(negedge clk);
            check("idle_ready", pready, 0);
            check("idle_prdata", prdata, 0);
            check("idle_pslverr", pslverr, 0);
        end
    endtask

    task automatic abort_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = 4'hF;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_ready", pready, 0);
        check("abort_pslverr", pslverr, 0);
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", pready, 0);
        check("reset_prdata", prdata, 0);
        check("reset_pslverr", pslverr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        apb_xfer(1, 32'h4, 32'hDEAD_BEEF, 4'hF);
        apb_xfer(0, 32'h4, 32'h0, 4'h0);
        check("rd_deadbeef", last_rd, 32'hDEAD_BEEF);
        idle(1, 0);

        apb_xfer(1, 32'h8, 32'h1122_3344, 4'hF);
        apb_xfer(1, 32'h8, 32'hAABB_CCDD, 4'h5);
        apb_xfer(1, 32'h8, 32'hFFFF_FFFF, 4'h0);
        apb_xfer(0, 32'h8, 32'h0, 4'h0);
        check("rd_strobe_merge", last_rd, 32'h11BB_33DD);
        idle(2, 1);

        apb_xfer(0, 32'h0, 32'h0, 4'h0);
        check("rd_id", last_rd, ID);
        apb_xfer(1, 32'h0, 32'h1234_5678, 4'hF);
        apb_xfer(0, 32'h0, 32'h0, 4'h0);
        apb_xfer(0, 32'h40, 32'h0, 4'h0);
        apb_xfer(0, 32'h6, 32'h0, 4'h0);
        apb_xfer(1, 32'h5, 32'h0BAD_0BAD, 4'hF);
        idle(1, 0);

        apb_xfer(1, 32'h10, 32'hCAFE_F00D, 4'hF);
        apb_xfer(0, 32'h10, 32'h0, 4'h0);
        check("b2b_read", last_rd, 32'hCAFE_F00D);
        abort_write(32'h10, 32'h5555_AAAA);
        idle(2, 0);
        apb_xfer(0, 32'h10, 32'h0, 4'h0);
        idle(1, 0);

        // reset in the middle of an access phase
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFF_FFFF;
        pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", pready, 0);
        check("async_rst_prdata", prdata, 0);
        check("async_rst_pslverr", pslverr, 0);
        model_clear();
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apb_xfer(0, 32'hC, 32'h0, 4'h0);
        check("rd_after_reset", last_rd, 0);
        apb_xfer(0, 32'h4, 32'h0, 4'h0);

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, NUM_REGS - 1)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, NUM_REGS - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'($urandom_range(NUM_REGS, 63)) * 4;
            else             a = $urandom;
            apb_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            r = $urandom_range(0, 2);
            if (r != 0) idle(r, 1'($urandom_range(0, 1)));
        end
        idle(1, 0);
        for (int i = 1; i < NUM_REGS; i++) apb_xfer(0, 32'(i * 4), 32'h0, 4'h0);
        idle(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
